// File: rtl/alu_result_reg.sv
// alu_result_reg: edge-triggered capture of the ALU result with history, B-operand feedback and sticky status
module alu_result_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] ALUout,
  input  logic [2:0]       Function,
  input  logic             Load,
  input  logic             Freeze,
  input  logic             Clear,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Prev,
  output logic [3:0]       Bfeed,
  output logic             Valid,
  output logic             Carry,
  output logic             Zero,
  output logic [CNT_W-1:0] OpCount,
  output logic             Busy
);
  typedef enum logic [1:0] {EMPTY, LOADED, FROZEN} state_t;
  state_t state;
  logic load_q;
  logic ld_edge;
  assign ld_edge = Load & ~load_q;
  assign Bfeed = Result[3:0];
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Result  <= '0;
      Prev    <= '0;
      Valid   <= 1'b0;
      Carry   <= 1'b0;
      Zero    <= 1'b0;
      OpCount <= '0;
      Busy    <= 1'b0;
      load_q  <= 1'b0;
      state   <= EMPTY;
    end else begin
      load_q <= Load;
      if (Clear) begin
        Result <= '0;
        Prev   <= '0;
        Valid  <= 1'b0;
        Carry  <= 1'b0;
        Zero   <= 1'b0;
        state  <= Freeze ? FROZEN : EMPTY;
        Busy   <= Freeze;
      end else if (Freeze) begin
        state <= FROZEN;
        Busy  <= 1'b1;
      end else if (state == FROZEN) begin
        state <= Valid ? LOADED : EMPTY;
        Busy  <= 1'b0;
      end else if (ld_edge) begin
        Prev    <= Result;
        Result  <= ALUout;
        Valid   <= 1'b1;
        Zero    <= ~|ALUout;
        Carry   <= Carry | (ALUout[4] & (Function[2:1] == 2'b00));
        OpCount <= OpCount + {{(CNT_W-1){1'b0}}, ~&OpCount};
        state   <= LOADED;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_reg.sv
// tb_alu_result_reg: directed vectors with hand-computed expectations for alu_result_reg
module tb_alu_result_reg;
  logic       Clock = 0, Reset = 1, Load = 0, Freeze = 0, Clear = 0;
  logic [7:0] ALUout = 0;
  logic [2:0] Function = 0;
  logic [7:0] Result, Prev, r2, p2, OpCount;
  logic [3:0] Bfeed, b2;
  logic       Valid, Carry, Zero, Busy, v2, c2, z2, busy2;
  logic [1:0] oc2;
  int vecs = 0, errs = 0;

  always #5 Clock = ~Clock;

  alu_result_reg u_dut (
    .Clock(Clock), .Reset(Reset), .ALUout(ALUout), .Function(Function), .Load(Load),
    .Freeze(Freeze), .Clear(Clear), .Result(Result), .Prev(Prev), .Bfeed(Bfeed),
    .Valid(Valid), .Carry(Carry), .Zero(Zero), .OpCount(OpCount), .Busy(Busy)
  );

  alu_result_reg #(.CNT_W(2)) u_sat (
    .Clock(Clock), .Reset(Reset), .ALUout(ALUout), .Function(Function), .Load(Load),
    .Freeze(Freeze), .Clear(Clear), .Result(r2), .Prev(p2), .Bfeed(b2),
    .Valid(v2), .Carry(c2), .Zero(z2), .OpCount(oc2), .Busy(busy2)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] r, input logic [7:0] p,
                         input logic v, input logic c, input logic z, input logic [7:0] n,
                         input logic b);
    chk({tag, ".Result"}, Result, r);
    chk({tag, ".Prev"}, Prev, p);
    chk({tag, ".Bfeed"}, Bfeed, r[3:0]);
    chk({tag, ".Valid"}, Valid, v);
    chk({tag, ".Carry"}, Carry, c);
    chk({tag, ".Zero"}, Zero, z);
    chk({tag, ".OpCount"}, OpCount, n);
    chk({tag, ".Busy"}, Busy, b);
  endtask

  initial begin
    step(); step();
    chk_all("reset", 8'h00, 8'h00, 0, 0, 0, 0, 0);
    Reset = 0;
    // 1: single capture from a held key
    ALUout = 8'h1C; Function = 3'b000; Load = 1;
    step();
    chk_all("t1_cap", 8'h1C, 8'h00, 1, 1, 0, 1, 0);
    ALUout = 8'h77;
    repeat (4) step();
    chk_all("t1_hold", 8'h1C, 8'h00, 1, 1, 0, 1, 0);
    Load = 0;
    step();
    // 2: two captures with a non-arithmetic function after a fresh reset
    Reset = 1; step(); Reset = 0;
    Function = 3'b101; ALUout = 8'h05; Load = 1; step();
    Load = 0; step();
    ALUout = 8'h0A; Load = 1; step();
    chk_all("t2", 8'h0A, 8'h05, 1, 0, 0, 2, 0);
    Load = 0; step();
    // 3: freeze blocks captures
    Freeze = 1; step();
    chk("t3_busy", Busy, 1);
    ALUout = 8'h33; Load = 1; step();
    Load = 0; step();
    chk_all("t3_frozen", 8'h0A, 8'h05, 1, 0, 0, 2, 1);
    Freeze = 0; step();
    chk_all("t3_thaw", 8'h0A, 8'h05, 1, 0, 0, 2, 0);
    Freeze = 1; ALUout = 8'h44; Load = 1; step();
    chk_all("t3_same_cycle", 8'h0A, 8'h05, 1, 0, 0, 2, 1);
    Freeze = 0; Load = 0; step();
    chk("t3_busy_off", Busy, 0);
    // 4: carry from function 001, then Clear wins over a load edge
    Function = 3'b001; ALUout = 8'h12; Load = 1; step();
    chk_all("t4_cap", 8'h12, 8'h0A, 1, 1, 0, 3, 0);
    Load = 0; step();
    Clear = 1; ALUout = 8'h00; Load = 1; step();
    chk_all("t4_clear", 8'h00, 8'h00, 0, 0, 0, 3, 0);
    Clear = 0; Load = 0; step();
    chk_all("t4_after", 8'h00, 8'h00, 0, 0, 0, 3, 0);
    // 5: saturating 2-bit counter
    Reset = 1; step(); Reset = 0;
    Function = 3'b010;
    for (int i = 0; i < 5; i++) begin
      ALUout = 8'(i + 1); Load = 1; step();
      chk("t5_sat_cnt", oc2, (i < 3) ? i + 1 : 3);
      chk("t5_cnt", OpCount, i + 1);
      Load = 0; step();
    end
    ALUout = 8'hDE; Function = 3'b111; Load = 1; step();
    chk_all("t5_default", 8'hDE, 8'h05, 1, 0, 0, 6, 0);
    Load = 0; step();
    // 6: zero flag keeps carry, then reset with the key held
    Function = 3'b000; ALUout = 8'h10; Load = 1; step();
    Load = 0; step();
    Function = 3'b011; ALUout = 8'h00; Load = 1; step();
    chk_all("t6_zero", 8'h00, 8'h10, 1, 1, 1, 8, 0);
    Reset = 1; ALUout = 8'h5A; step();
    chk_all("t6_reset", 8'h00, 8'h00, 0, 0, 0, 0, 0);
    Reset = 0; step();
    chk_all("t6_first", 8'h5A, 8'h00, 1, 0, 0, 1, 0);
    step();
    chk("t6_once", OpCount, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
